// File: rtl/fp_scan_pkg.sv
// Shared types and constants for the front-panel readback scanner.
package fp_scan_pkg;

    localparam int DATA_W    = 8;   // fpd bus width
    localparam int SLOT_W    = 4;   // slot index width
    localparam int CNT_W     = 4;   // settle/gap phase counter width
    localparam int MAX_SLOTS = 16;  // strobe lines and shadow entries per bank

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_GAP,
        ST_SWAP
    } state_e;

    // Readback slot assignment on the front-panel bus.
    localparam logic [SLOT_W-1:0] SLOT_PCH   = 4'd0;
    localparam logic [SLOT_W-1:0] SLOT_PCL   = 4'd1;
    localparam logic [SLOT_W-1:0] SLOT_DRH   = 4'd2;
    localparam logic [SLOT_W-1:0] SLOT_DRL   = 4'd3;
    localparam logic [SLOT_W-1:0] SLOT_ACH   = 4'd4;
    localparam logic [SLOT_W-1:0] SLOT_ACL   = 4'd5;
    localparam logic [SLOT_W-1:0] SLOT_SPH   = 4'd6;
    localparam logic [SLOT_W-1:0] SLOT_SPL   = 4'd7;
    localparam logic [SLOT_W-1:0] SLOT_IRH   = 4'd8;
    localparam logic [SLOT_W-1:0] SLOT_IRL   = 4'd9;
    localparam logic [SLOT_W-1:0] SLOT_FLAGS = 4'd10;
    localparam logic [SLOT_W-1:0] SLOT_UA0   = 4'd11;
    localparam logic [SLOT_W-1:0] SLOT_UC0   = 4'd12;
    localparam logic [SLOT_W-1:0] SLOT_UC1   = 4'd13;
    localparam logic [SLOT_W-1:0] SLOT_UC2   = 4'd14;
    localparam logic [SLOT_W-1:0] SLOT_ARH   = 4'd15;

    // Active-low one-hot strobe pattern for a slot.
    function automatic logic [MAX_SLOTS-1:0] strobe_mask(input logic [SLOT_W-1:0] slot);
        strobe_mask       = '1;
        strobe_mask[slot] = 1'b0;
    endfunction

endpackage

// File: rtl/fp_shadow_ram.sv
// Double-buffered 16x8 shadow store: the scanner writes the back bank while
// the host reads a stable frame from the front bank.
module fp_shadow_ram
    import fp_scan_pkg::*;
(
    input  logic              clk1,
    input  logic              nreset,
    input  logic              bank_sel,   // selects the front bank; back is the other one
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SLOT_W-1:0] rd_addr,
    input  logic              rd_valid,   // low for slots outside the scanned range
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2][MAX_SLOTS];
    logic [DATA_W-1:0] mem_d [2][MAX_SLOTS];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              back_sel;

    assign back_sel = ~bank_sel;
    assign rd_data  = rd_data_q;

    // Next-state of the storage (back-bank write) and the front-bank read.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
        mem_d     = mem_q;
        rd_data_d = '0;
        if (wr_en) begin
            mem_d[back_sel][wr_addr] = wr_data;
        end
        if (rd_valid) begin
            rd_data_d = mem_q[bank_sel][rd_addr];
        end
    end

    // Storage and read register.
    always_ff @(posedge clk1 or negedge nreset) begin
        // NOTE: both banks are flops with async reset so a snapshot read right after reset is defined as zero; sequential state uses non-blocking '<='.
        if (!nreset) begin
            mem_q     <= '{default: '0};
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/fp_scanner.sv
// Front-panel readback scanner: strobes each card slot in turn, samples fpd
// into the back bank and swaps banks once per complete frame.
module fp_scanner
    import fp_scan_pkg::*;
#(
    parameter int NSLOTS = 16,  // slots scanned per frame (2..16)
    parameter int SETTLE = 4,   // strobe-low cycles before sampling (1..15)
    parameter int GAP    = 2    // all-high turnaround cycles between slots (1..15)
) (
    input  logic                 clk1,
    input  logic                 nreset,
    input  logic                 run,
    input  logic                 single,
    input  logic [DATA_W-1:0]    fpd,
    output logic [MAX_SLOTS-1:0] nfpstb,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           frame_cnt,
    input  logic [SLOT_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]    rd_data
);

    localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(NSLOTS - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP - 1);

    state_e                state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic                  bank_sel_q, bank_sel_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
    logic [MAX_SLOTS-1:0]  nfpstb_q, nfpstb_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  wr_en;
    logic                  rd_valid;

    assign nfpstb     = nfpstb_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign rd_valid   = int'(rd_addr) < NSLOTS;

    // Next-state logic; strobe and status outputs are decoded from the next
    // state so they leave flops cleanly and release on reset.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q | single;
        bank_sel_d  = bank_sel_q;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run || pending_q || single) begin
                    state_d   = ST_STROBE;
                    slot_d    = '0;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end
            end
            ST_STROBE: begin
                if (cnt_q == SETTLE_LAST) begin
                    wr_en   = 1'b1;     // strobe is still low at this edge
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (slot_q == LAST_SLOT) begin
                        state_d     = ST_SWAP;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        slot_d  = slot_q + SLOT_W'(1);
                        state_d = ST_STROBE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SWAP: begin
                bank_sel_d = ~bank_sel_q;
                cnt_d      = '0;
                slot_d     = '0;
                if (run || pending_q) begin
                    state_d   = ST_STROBE;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        nfpstb_d     = (state_d == ST_STROBE) ? strobe_mask(slot_d) : '1;
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_SWAP);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            bank_sel_q   <= 1'b0;
            frame_cnt_q  <= '0;
            nfpstb_q     <= '1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            bank_sel_q   <= bank_sel_d;
            frame_cnt_q  <= frame_cnt_d;
            nfpstb_q     <= nfpstb_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    fp_shadow_ram u_shadow (
        .clk1     (clk1),
        .nreset   (nreset),
        .bank_sel (bank_sel_q),
        .wr_en    (wr_en),
        .wr_addr  (slot_q),
        .wr_data  (fpd),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_fp_scanner.sv
// Directed bench for fp_scanner with a simple card model on the fpd bus.
module tb_fp_scanner;

    logic        clk1 = 1'b0;
    logic        nreset;
    logic        run;
    logic        single;
    logic [7:0]  fpd;
    logic [15:0] nfpstb;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;

    logic [7:0]  fp_base;   // strobed card i returns fp_base + i
    int          n_vec = 0;
    int          n_bad = 0;

    fp_scanner dut (
        .clk1       (clk1),
        .nreset     (nreset),
        .run        (run),
        .single     (single),
        .fpd        (fpd),
        .nfpstb     (nfpstb),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk1 = ~clk1;

    // Card model: whichever card sees its strobe low drives the bus.
    always_comb begin
        fpd = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (!nfpstb[i]) fpd = fp_base + 8'(i);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk1);
    endtask

    task automatic wait_low(input int idx, input int budget, input string tag);
        bit found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            tick();
            if (nfpstb[idx] == 1'b0) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            tick();
            if (frame_done) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int          n;
        int          errs;
        int          frames;
        bit          found;
        logic [15:0] exp_stb;

        nreset  = 1'b0;
        run     = 1'b0;
        single  = 1'b0;
        rd_addr = 4'd0;
        fp_base = 8'h10;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_nfpstb", 32'(nfpstb), 32'hFFFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        nreset = 1'b1;
        repeat (5) tick();
        check("idle_nfpstb", 32'(nfpstb), 32'hFFFF);
        check("idle_busy", 32'(busy), 32'd0);

        // ---- one-shot frame ----
        single = 1'b1;
        tick();
        single = 1'b0;
        check("oneshot_first_strobe", 32'(nfpstb), 32'hFFFE);
        n = 0;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (busy) n++;
            if (frame_done) found = 1'b1;
            else tick();
        end
        check("oneshot_done_seen", 32'(found), 32'd1);
        check("oneshot_frame_len", 32'(n), 32'd97);
        tick();
        check("oneshot_busy_after", 32'(busy), 32'd0);
        check("oneshot_frame_cnt", 32'(frame_cnt), 32'd1);
        rd_addr = 4'd5;
        tick();
        check("oneshot_rd5", 32'(rd_data), 32'h15);
        rd_addr = 4'd0;
        tick();
        check("oneshot_rd0", 32'(rd_data), 32'h10);
        rd_addr = 4'd15;
        tick();
        check("oneshot_rd15", 32'(rd_data), 32'h1F);

        // ---- strobe timing over two back-to-back frames ----
        run  = 1'b1;
        errs = 0;
        for (int k = 0; k < 194; k++) begin
            int p;
            tick();
            p = k % 97;
            exp_stb = 16'hFFFF;
            if (p != 96 && (p % 6) < 4) exp_stb[p / 6] = 1'b0;
            if (nfpstb !== exp_stb) errs++;
            if (frame_done !== (p == 96)) errs++;
            if (busy !== 1'b1) errs++;
            if ($countones(~nfpstb) > 1) errs++;
        end
        check("strobe_seq_errors", 32'(errs), 32'd0);
        check("strobe_frame_cnt", 32'(frame_cnt), 32'd3);

        // ---- coherency: new data becomes visible only after SWAP ----
        fp_base = 8'hA0;
        rd_addr = 4'd3;
        errs    = 0;
        found   = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (rd_data !== 8'h13) errs++;
            if (frame_done) found = 1'b1;
        end
        check("coh_done_seen", 32'(found), 32'd1);
        check("coh_old_reads", 32'(errs), 32'd0);
        tick();
        check("coh_swap_cycle_read", 32'(rd_data), 32'h13);
        tick();
        check("coh_new_read", 32'(rd_data), 32'hA3);
        check("coh_frame_cnt", 32'(frame_cnt), 32'd4);

        // ---- run dropped mid-frame ----
        fp_base = 8'h50;
        wait_low(7, 100, "rundrop_slot7");
        run = 1'b0;
        wait_done(200, "rundrop_done");
        tick();
        check("rundrop_frame_cnt", 32'(frame_cnt), 32'd5);
        rd_addr = 4'd7;
        errs = 0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (nfpstb !== 16'hFFFF || busy !== 1'b0 || frame_done !== 1'b0) errs++;
        end
        check("rundrop_quiet", 32'(errs), 32'd0);
        check("rundrop_rd7", 32'(rd_data), 32'h57);

        // ---- single while busy gives exactly one more frame ----
        fp_base = 8'h60;
        single = 1'b1;
        tick();
        single = 1'b0;
        wait_low(7, 100, "pend_slot7");
        single = 1'b1;
        tick();
        single = 1'b0;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (frame_done) n++;
        end
        check("pend_frames", 32'(n), 32'd2);
        check("pend_frame_cnt", 32'(frame_cnt), 32'd7);
        check("pend_busy", 32'(busy), 32'd0);

        // ---- reset asserted mid-scan ----
        run = 1'b1;
        wait_low(3, 150, "midrst_slot3");
        nreset = 1'b0;
        #1;
        check("midrst_nfpstb", 32'(nfpstb), 32'hFFFF);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        tick();
        nreset = 1'b1;
        tick();
        check("midrst_bank_cleared", 32'(rd_data), 32'd0);

        // ---- frame counter wrap ----
        frames = 0;
        for (int k = 0; k < 30000 && frames < 255; k++) begin
            tick();
            if (frame_done) frames++;
        end
        check("wrap_255_frames", 32'(frames), 32'd255);
        tick();
        check("wrap_cnt_255", 32'(frame_cnt), 32'd255);
        wait_done(200, "wrap_last_done");
        tick();
        check("wrap_cnt_0", 32'(frame_cnt), 32'd0);

        run = 1'b0;
        wait_done(200, "final_done");
        tick();
        check("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
